butterfly_writeback: RTL

Sink at the output end of the butterfly pipeline. It accepts butterfly result beats over the AXI control handshake and rounds and saturates each full-precision component back to the data word length. It writes the two complex results in place to the sample memory at addresses generated internally for a radix-2 in-place FFT. It tracks butterfly and stage progress, and signals completion after the last butterfly of the last stage.

---
 rtl/butterfly_writeback.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/butterfly_writeback.sv
// rtl/butterfly_writeback.sv - radix-2 in-place FFT writeback: round/saturate, address generation, progress tracking.
// Optional BUTTERFLY_WB_SATCNT_EN adds a saturating clip counter output sat_cnt_o.
module butterfly_writeback #(
  parameter int width     = 9,
  parameter int intrwidth = 24,
  parameter int log2n     = 3,
  parameter int shift     = 14,
  localparam int sw       = (log2n > 1) ? $clog2(log2n) : 1,
  localparam int kw       = (log2n > 1) ? log2n - 1 : 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [0:3][intrwidth-1:0]    data_i,
  input  logic                         start_i,
  output logic                         wr_en_o,
  output logic [log2n-1:0]             wr_addr_a_o,
  output logic [log2n-1:0]             wr_addr_b_o,
  output logic [2*width-1:0]           wr_data_a_o,
  output logic [2*width-1:0]           wr_data_b_o,
  output logic [sw-1:0]                stage_o,
  output logic                         busy_o,
  output logic                         done_o
`ifdef BUTTERFLY_WB_SATCNT_EN
  ,
  output logic [7:0]                   sat_cnt_o
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic signed [intrwidth:0] half  = (intrwidth+1)'(1 << (shift - 1));
  localparam logic signed [intrwidth:0] max_v = (intrwidth+1)'((1 << (width - 1)) - 1);
  localparam logic signed [intrwidth:0] min_v = (intrwidth+1)'(-(1 << (width - 1)));
  localparam logic [kw-1:0]             k_max = kw'((1 << (log2n - 1)) - 1);
  localparam logic [sw-1:0]             s_max = sw'(log2n - 1);

  state_t          state_q, state_d;
  logic [kw-1:0]   k_q, k_d;
  logic [sw-1:0]   s_q, s_d;
  logic            hs, last, start_acc;
  logic [log2n-1:0] k_ext, span, addr_a, addr_b;

  logic signed [intrwidth:0] r_full [4];
  logic [width-1:0]          r_sat  [4];

  // One extra bit keeps the rounding offset from overflowing near full scale.
  function automatic logic signed [intrwidth:0] round_full(input logic [intrwidth-1:0] v);
    logic signed [intrwidth:0] sum;
    sum = $signed({v[intrwidth-1], v}) + half;
    return sum >>> shift;
  endfunction

  assign s_axis_tready = (state_q == RUN);
  assign busy_o        = (state_q == RUN);
  assign stage_o       = s_q;
  assign hs            = s_axis_tvalid && (state_q == RUN);
  assign last          = (k_q == k_max) && (s_q == s_max);
  assign start_acc     = (state_q == IDLE) && start_i;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      r_full[i] = round_full(data_i[i]);
      if (r_full[i] > max_v)      r_sat[i] = max_v[width-1:0];
      else if (r_full[i] < min_v) r_sat[i] = min_v[width-1:0];
      else                        r_sat[i] = r_full[i][width-1:0];
    end
  end

  // Group index shifted up past the pair span, plus position inside the span.
  always_comb begin
    k_ext  = log2n'(k_q);
    span   = log2n'(1) << s_q;
    addr_a = ((k_ext >> s_q) << (int'(s_q) + 1)) | (k_ext & (span - log2n'(1)));
    addr_b = addr_a | span;
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          k_d     = '0;
          s_d     = '0;
        end
      end
      RUN: begin
        if (hs) begin
          if (k_q == k_max) begin
            k_d = '0;
            if (s_q == s_max) begin
              s_d     = '0;
              state_d = IDLE;
            end else begin
              s_d = s_q + sw'(1);
            end
          end else begin
            k_d = k_q + kw'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      k_q         <= '0;
      s_q         <= '0;
      wr_en_o     <= 1'b0;
      done_o      <= 1'b0;
      wr_addr_a_o <= '0;
      wr_addr_b_o <= '0;
      wr_data_a_o <= '0;
      wr_data_b_o <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      wr_en_o <= hs;
      done_o  <= hs && last;
      if (hs) begin
        wr_addr_a_o <= addr_a;
        wr_addr_b_o <= addr_b;
        wr_data_a_o <= {r_sat[0], r_sat[1]};
        wr_data_b_o <= {r_sat[2], r_sat[3]};
      end
    end
  end

`ifdef BUTTERFLY_WB_SATCNT_EN
  logic [3:0] clip;
  logic [8:0] sat_sum;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      clip[i] = (r_full[i] > max_v) || (r_full[i] < min_v);
    end
    sat_sum = {1'b0, sat_cnt_o} + 9'(clip[0]) + 9'(clip[1]) + 9'(clip[2]) + 9'(clip[3]);
  end

  always_ff @(posedge clk) begin
    if (!rstn)          sat_cnt_o <= '0;
    else if (start_acc) sat_cnt_o <= '0;
    else if (hs)        sat_cnt_o <= sat_sum[8] ? 8'hFF : sat_sum[7:0];
  end
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule
